vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 38 +++
 rtl/pixel_tick_div.sv | 35 +++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 Hz timing constants.
// Holds the default porch/sync/visible sizes, the derived line/frame totals
// and the sync window bounds, so the timing generator and the pixel
// generator agree on one visible-area definition. No ports.
package vga_pkg;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;

    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_CLK_DIV      = 4;
    localparam int unsigned DEF_SCREEN_WIDTH = 10;
    localparam int unsigned DEF_PIXEL_WIDTH  = 12;

    localparam int unsigned VGA_H_TOTAL =
        DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned VGA_V_TOTAL =
        DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned VGA_HSYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int unsigned VGA_HSYNC_END   = VGA_HSYNC_START + DEF_H_SYNC;
    localparam int unsigned VGA_VSYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int unsigned VGA_VSYNC_END   = VGA_VSYNC_START + DEF_V_SYNC;

    // Half-open window test [lo, hi), unsigned.
    function automatic logic in_window(input int unsigned value,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate enable generator.
// Counts sys_clk cycles 0..CLK_DIV-1 and emits a registered one-cycle
// p_tick in the cycle after the counter reaches CLK_DIV-1.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   p_tick  out  one-clk pixel enable, every CLK_DIV cycles
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            p_tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with aligned colour/sync output stage.
// Produces pixel coordinates, video_on and the pixel tick for the pixel
// generator, then registers its colour together with hsync/vsync on each
// pixel tick so the three reach the VGA port on the same edge.
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   rgb_in       in   colour from pixel generator for current (x, y)
//   x, y         out  current horizontal / vertical count
//   video_on     out  (x, y) inside the visible area
//   p_tick       out  one-sys_clk pixel enable
//   frame_start  out  one-sys_clk pulse as the raster wraps to (0, 0)
//   hsync, vsync out  active-low syncs, registered
//   vga_rgb      out  registered colour, zero during blanking
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY    = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT      = DEF_H_FRONT,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BACK       = DEF_H_BACK,
    parameter int unsigned V_DISPLAY    = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT      = DEF_V_FRONT,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BACK       = DEF_V_BACK,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned SCREEN_WIDTH = DEF_SCREEN_WIDTH,
    parameter int unsigned PIXEL_WIDTH  = DEF_PIXEL_WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [PIXEL_WIDTH-1:0]  rgb_in,
    output logic [SCREEN_WIDTH-1:0] x,
    output logic [SCREEN_WIDTH-1:0] y,
    output logic                    video_on,
    output logic                    p_tick,
    output logic                    frame_start,
    output logic                    hsync,
    output logic                    vsync,
    output logic [PIXEL_WIDTH-1:0]  vga_rgb
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [SCREEN_WIDTH-1:0] H_LAST = SCREEN_WIDTH'(H_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] V_LAST = SCREEN_WIDTH'(V_TOTAL - 1);

    logic [SCREEN_WIDTH-1:0] h_cnt;
    logic [SCREEN_WIDTH-1:0] v_cnt;
    logic                    h_last;
    logic                    v_last;
    logic                    hsync_act;
    logic                    vsync_act;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .p_tick (p_tick)
    );

    always_comb begin
        h_last      = (h_cnt == H_LAST);
        v_last      = (v_cnt == V_LAST);
        video_on    = (32'(h_cnt) < H_DISPLAY) && (32'(v_cnt) < V_DISPLAY);
        hsync_act   = in_window(32'(h_cnt), HS_START, HS_END);
        vsync_act   = in_window(32'(v_cnt), VS_START, VS_END);
        // Combinational so it coincides with the tick on which both counters wrap.
        frame_start = p_tick && h_last && v_last;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Colour and syncs are captured from the same counter state on the same
    // tick, so the port shows pixel (x, y) one pixel period after x/y do.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            vga_rgb <= '0;
        end else if (p_tick) begin
            hsync   <= ~hsync_act;
            vsync   <= ~vsync_act;
            vga_rgb <= video_on ? rgb_in : '0;
        end
    end

    assign x = h_cnt;
    assign y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a scaled raster:
//   H: 16 visible, 2 front, 4 sync, 3 back -> 25 per line, hsync on x in [18,22)
//   V:  6 visible, 2 front, 2 sync, 3 back -> 13 lines,   vsync on y in [8,10)
//   CLK_DIV = 4 -> frame = 25*13*4 = 1300 sys_clk cycles
// At each p_tick sample point x/y show the current pixel and the VGA pins
// show the pixel of the previous tick.
module tb_vga_timing_gen;

    logic        clk;
    logic        rst_n;
    logic [11:0] rgb_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        p_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [11:0] vga_rgb;

    logic        use_x;
    logic [11:0] rgb_const;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    vga_timing_gen #(
        .H_DISPLAY    (16),
        .H_FRONT      (2),
        .H_SYNC       (4),
        .H_BACK       (3),
        .V_DISPLAY    (6),
        .V_FRONT      (2),
        .V_SYNC       (2),
        .V_BACK       (3),
        .CLK_DIV      (4),
        .SCREEN_WIDTH (10),
        .PIXEL_WIDTH  (12)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .rgb_in      (rgb_in),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .p_tick      (p_tick),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_rgb     (vga_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the combinational pixel generator.
    always_comb rgb_in = use_x ? {2'b00, x} : rgb_const;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Advance to the next sample point where p_tick is high.
    task automatic next_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!p_tick && n < 16);
        if (!p_tick) timeout("p_tick_wait");
    endtask

    task automatic wait_pix(input int px, input int py);
        int n = 0;
        do begin
            next_tick();
            n++;
        end while (!(x == 10'(px) && y == 10'(py)) && n < 400);
        if (!(x == 10'(px) && y == 10'(py))) timeout("pixel_wait");
    endtask

    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2000);
        if (!frame_start) timeout("frame_start_wait");
    endtask

    initial begin
        int low_ticks;
        int t0;
        int rel;
        int fff_cnt;
        int other_cnt;
        int run;
        int runs;
        int longest;

        rst_n     = 1'b0;
        use_x     = 1'b0;
        rgb_const = 12'hFFF;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_p_tick", p_tick, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_vga_rgb", vga_rgb, 0);
        check("rst_video_on", video_on, 1);

        // Release: ticks on cycles 4, 8, 12
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("tick_phase", p_tick, (k % 4 == 0) ? 1 : 0);
            if (k == 4) check("first_tick_x", x, 0);
            if (k == 5) check("first_pixel_rgb", vga_rgb, 12'hFFF);
            if (k == 8) check("second_tick_x", x, 1);
        end

        // Horizontal sync
        wait_pix(18, 0);
        check("hsync_before", hsync, 1);
        next_tick();
        check("hsync_fall_x", x, 19);
        check("hsync_fall", hsync, 0);
        low_ticks = 1;
        while (hsync == 1'b0 && low_ticks < 30) begin
            next_tick();
            if (hsync == 1'b0) low_ticks++;
        end
        check("hsync_low_ticks", low_ticks, 4);
        check("hsync_rise_x", x, 23);

        // Vertical sync
        wait_pix(0, 8);
        check("vsync_before", vsync, 1);
        next_tick();
        check("vsync_fall", vsync, 0);
        low_ticks = 1;
        while (vsync == 1'b0 && low_ticks < 200) begin
            next_tick();
            if (vsync == 1'b0) low_ticks++;
        end
        check("vsync_low_ticks", low_ticks, 50);
        check("vsync_rise_x", x, 1);
        check("vsync_rise_y", y, 10);

        // Frame period
        wait_frame_start();
        check("fs_x", x, 24);
        check("fs_y", y, 12);
        t0 = cyc;
        @(negedge clk);
        check("fs_one_cycle", frame_start, 0);
        wait_frame_start();
        check("frame_period", cyc - t0, 1300);

        // Blanking gate over one full frame of constant white
        fff_cnt   = 0;
        other_cnt = 0;
        run       = 0;
        runs      = 0;
        longest   = 0;
        for (int i = 0; i < 325; i++) begin
            next_tick();
            if (vga_rgb == 12'hFFF) begin
                fff_cnt++;
                run++;
            end else begin
                if (vga_rgb != 12'h000) other_cnt++;
                if (run > 0) begin
                    runs++;
                    if (run > longest) longest = run;
                    run = 0;
                end
            end
        end
        check("visible_pixels", fff_cnt, 96);
        check("blank_nonzero", other_cnt, 0);
        check("visible_runs", runs, 6);
        check("run_length", longest, 16);

        // Alignment: colour follows x by one pixel period
        use_x = 1'b1;
        wait_pix(0, 1);
        check("align_blank", vga_rgb, 0);
        for (int i = 1; i <= 16; i++) begin
            next_tick();
            check("align_rgb", vga_rgb, i - 1);
        end

        // Mid-frame reset at (12, 3)
        wait_pix(12, 3);
        check("pre_reset_rgb", vga_rgb, 11);
        rst_n = 1'b0;
        #1;
        check("mrst_x", x, 0);
        check("mrst_y", y, 0);
        check("mrst_p_tick", p_tick, 0);
        check("mrst_frame_start", frame_start, 0);
        check("mrst_hsync", hsync, 1);
        check("mrst_vsync", vsync, 1);
        check("mrst_vga_rgb", vga_rgb, 0);
        repeat (3) @(negedge clk);
        check("mrst_video_on", video_on, 1);
        rst_n = 1'b1;
        rel = cyc;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("mrst_tick_phase", p_tick, (k == 4) ? 1 : 0);
        end
        check("mrst_resume_x", x, 0);
        check("mrst_resume_y", y, 0);
        wait_pix(18, 0);
        check("mrst_hsync_before", hsync, 1);
        next_tick();
        check("mrst_hsync_fall", hsync, 0);
        wait_frame_start();
        check("mrst_frame_start_cycle", cyc - rel, 1300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
